punc_program_loader: RTL and testbench
======================================

// Module: punc_program_loader
// PURPOSE
//   Upstream boot stage for the PUnC LC3 core. Accepts a host byte stream (valid/ready),
//   assembles 16-bit words, writes a program image into PUnC memory through a dedicated
//   write port, and verifies a trailing checksum. Holds the core in reset (cpu_rst) until
//   the image is accepted; releases it only on a good load.
// PARAMETERS
//   TIMEOUT   1024  inter-byte timeout in clk cycles while a frame is open; 0 disables
//   CNT_W     11    width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//   clk             in   1   clock, all state on rising edge
//   rst             in   1   asynchronous, active-low reset
//   in_data         in   8   host byte
//   in_valid        in   1   host byte valid
//   in_ready        out  1   loader can accept a byte; transfer when in_valid & in_ready
//   reload          in   1   1-cycle pulse: abandon RUN/ERROR, return to IDLE
//   mem_w_en        out  1   memory write strobe, 1 cycle per data word
//   mem_w_addr      out  16  memory word address
//   mem_w_data      out  16  memory write data
//   cpu_rst         out  1   active-high reset to the PUnC core
//   loaded          out  1   1 while in RUN
//   error           out  1   1 while in ERROR
//   err_code        out  2   0 none, 1 checksum mismatch, 2 timeout
//   words_written   out  16  data words written in the current frame
// BEHAVIOUR
//   Frame (bytes, high byte first per word): START_ADDR, COUNT, COUNT data words, CSUM.
//   CSUM = 16-bit sum (mod 2^16) of all data words only; header not included.
//   States: IDLE, ADDR, COUNT, DATA, CSUM, RUN, ERROR. A byte-phase flag (hi/lo) tracks
//   position within a word; it clears on every state change.
//   Reset (rst=0, async): state IDLE, in_ready=0 until first clk after deassert, then 1;
//     mem_w_en=0, mem_w_addr=0, mem_w_data=0, cpu_rst=1, loaded=0, error=0, err_code=0,
//     words_written=0, checksum accumulator=0, timeout counter=0.
//   in_ready=1 in IDLE/ADDR/COUNT/DATA/CSUM; 0 in RUN/ERROR. Never depends combinationally
//     on in_valid.
//   IDLE: first accepted byte is ADDR high byte -> state ADDR (lo phase). No timeout in IDLE.
//   ADDR: lo byte completes START_ADDR -> COUNT. COUNT: lo byte completes COUNT;
//     COUNT!=0 -> DATA, COUNT==0 -> CSUM directly (no writes).
//   DATA: on acceptance of the lo byte of word i, next cycle: mem_w_en=1 for exactly 1 cycle,
//     mem_w_addr=START_ADDR+i (mod 2^16, wraps 0xFFFF->0x0000), mem_w_data=word;
//     checksum += word; words_written increments same cycle. After word COUNT-1 -> CSUM.
//     Back-to-back bytes every cycle supported: max one write per 2 cycles.
//   CSUM: lo byte completes received sum; equal to accumulator -> RUN, else ERROR code 1.
//   RUN: cpu_rst=0, loaded=1 from the first cycle in RUN. Stays until reload or reset.
//   ERROR: cpu_rst=1, error=1, err_code held. Stays until reload or reset.
//   reload (honoured in RUN/ERROR only, ignored elsewhere): next cycle IDLE, cpu_rst=1,
//     loaded=0, error=0, err_code=0, words_written=0, accumulator=0.
//   Timeout (TIMEOUT>0): counter clears on each accepted byte and on entry to ADDR; counts
//     each cycle in ADDR/COUNT/DATA/CSUM without an accepted byte; reaching TIMEOUT -> ERROR
//     code 2 next cycle. A byte accepted in the same cycle the counter hits TIMEOUT wins
//     (counter clears, no error).
//   mem_w_addr/mem_w_data hold last values when mem_w_en=0. No memory write outside DATA.
//   Reset mid-frame: all state discarded immediately; partial words never written.
// TESTING
//   1. Frame 30 00|00 03|12 34|AB CD|00 01|BE 02, one byte/cycle -> writes (0x3000,0x1234),
//      (0x3001,0xABCD),(0x3002,0x0001) each 1-cycle strobe; RUN, cpu_rst 1->0, words_written=3.
//   2. Same frame with CSUM 0xBE03 -> no RUN; error=1, err_code=1, cpu_rst=1; then reload ->
//      IDLE, error=0, and a correct resend reaches RUN.
//   3. START_ADDR=0xFFFF, COUNT=2, data 0x0005,0x0006, CSUM 0x000B -> writes at 0xFFFF then
//      0x0000; RUN.
//   4. COUNT=0, CSUM=0x0000 -> no mem_w_en pulse at all; RUN with words_written=0.
//   5. TIMEOUT=16: send 3 bytes then stall in_valid 16 cycles -> ERROR code 2; stall of 15
//      cycles then resume -> completes normally.
//   6. Assert rst low mid-DATA after a hi byte -> outputs at reset values asynchronously;
//      fresh frame after release loads correctly; random in_valid gaps give identical writes.

Source files
------------

// File: rtl/punc_program_loader.sv
// Purpose: boot loader for the PUnC core. It takes a host byte stream, builds 16-bit
//   words and writes the program image. It holds cpu_rst until the trailing checksum matches.
// Latency: a data word is written one cycle after its low byte is accepted.
//   RUN or ERROR follows one cycle after the checksum low byte.
// Backpressure: in_ready is registered and depends only on state. It is 1 in
//   IDLE/ADDR/COUNT/DATA/CSUM and 0 in RUN/ERROR. It is also 0 for the first cycle after reset.
// Ports:
//   clk, rst (async active-low); in_data/in_valid/in_ready: host byte stream;
//   reload: leave RUN/ERROR; mem_w_en/mem_w_addr/mem_w_data: program memory write port;
//   cpu_rst/loaded/error/err_code: boot status; words_written: data words written in this frame.
module punc_program_loader #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_w_en,
  output logic [15:0] mem_w_addr,
  output logic [15:0] mem_w_data,
  output logic        cpu_rst,
  output logic        loaded,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CSUM, S_RUN, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TOUT = 2'd2;

  // The last idle count that is still allowed. One more idle cycle opens the error path.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t      state_q, state_d;
  logic        lo_q, lo_d;            // 1: the next byte is the low byte of the current word
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] start_addr_q, start_addr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] ww_q, ww_d;
  logic [15:0] acc_q, acc_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        wen_q, wen_d;
  logic [15:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        in_ready_q, in_ready_d;

  logic        take;
  logic [15:0] word;
  logic        frame_open;

  assign take       = in_valid & in_ready_q;
  assign word       = {hi_byte_q, in_data};
  assign frame_open = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    hi_byte_d    = hi_byte_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;
    ww_d         = ww_q;
    acc_d        = acc_q;
    tcnt_d       = '0;
    err_code_d   = err_code_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          // The first byte is already the address high byte, so ADDR starts in the low phase.
          hi_byte_d = in_data;
          lo_d      = 1'b1;
          ww_d      = '0;
          acc_d     = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR, S_COUNT, S_DATA, S_CSUM: begin
        if (take && !lo_q) begin
          hi_byte_d = in_data;
          lo_d      = 1'b1;
        end else if (take) begin
          lo_d = 1'b0;
          case (state_q)
            S_ADDR: begin
              start_addr_d = word;
              state_d      = S_COUNT;
            end
            S_COUNT: begin
              count_d = word;
              state_d = (word == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
              wen_d   = 1'b1;
              waddr_d = start_addr_q + ww_q;   // wraps 0xFFFF -> 0x0000
              wdata_d = word;
              acc_d   = acc_q + word;
              ww_d    = ww_q + 16'd1;
              if (ww_q + 16'd1 == count_q) state_d = S_CSUM;
            end
            default: begin
              if (word == acc_q) begin
                state_d = S_RUN;
              end else begin
                state_d    = S_ERROR;
                err_code_d = ERR_CSUM;
              end
            end
          endcase
        end

        // A byte accepted in the cycle that would expire the timer clears it.
        if (TIMEOUT > 0 && !take) begin
          if (tcnt_q == TO_LAST) begin
            state_d    = S_ERROR;
            err_code_d = ERR_TOUT;
            lo_d       = 1'b0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin  // S_RUN, S_ERROR
        if (reload) begin
          state_d    = S_IDLE;
          lo_d       = 1'b0;
          ww_d       = '0;
          acc_d      = '0;
          err_code_d = ERR_NONE;
        end
      end
    endcase

    in_ready_d = (state_d != S_RUN) && (state_d != S_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lo_q         <= 1'b0;
      hi_byte_q    <= '0;
      start_addr_q <= '0;
      count_q      <= '0;
      ww_q         <= '0;
      acc_q        <= '0;
      tcnt_q       <= '0;
      err_code_q   <= ERR_NONE;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      hi_byte_q    <= hi_byte_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      ww_q         <= ww_d;
      acc_q        <= acc_d;
      tcnt_q       <= frame_open ? tcnt_d : '0;
      err_code_q   <= err_code_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_w_en      = wen_q;
  assign mem_w_addr    = waddr_q;
  assign mem_w_data    = wdata_q;
  assign cpu_rst       = (state_q != S_RUN);
  assign loaded        = (state_q == S_RUN);
  assign error         = (state_q == S_ERROR);
  assign err_code      = err_code_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_punc_program_loader.sv
// Bench for punc_program_loader. A byte-index model of the frame predicts every output
// on every cycle. Directed frames with hand-computed writes and status then pin the model.
module tb_punc_program_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        mem_w_en;
  logic [15:0] mem_w_addr;
  logic [15:0] mem_w_data;
  logic        cpu_rst;
  logic        loaded;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  punc_program_loader #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .cpu_rst(cpu_rst), .loaded(loaded), .error(error), .err_code(err_code),
    .words_written(words_written)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the frame is a byte count n.
  // Bytes 0-1 hold addr, bytes 2-3 hold count, then 2*count data bytes, then 2 checksum bytes.
  int          m_n, m_idle, m_cnt, t_d;
  int          m_status;            // 0 collecting, 1 run, 2 error
  logic [7:0]  m_hi;
  logic [15:0] m_addr, m_sum, m_ww, e_waddr, e_wdata, t_w;
  logic [1:0]  m_ec;
  bit          e_wen, m_rdy, t_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n = 0; m_idle = 0; m_cnt = 0; m_status = 0; m_hi = 0; m_addr = 0;
      m_sum = 0; m_ww = 0; e_waddr = 0; e_wdata = 0; m_ec = 0; e_wen = 0; m_rdy = 0;
    end else begin
      t_acc = in_valid && m_rdy;
      e_wen = 0;
      if (m_status != 0) begin
        if (reload) begin
          m_status = 0; m_n = 0; m_ww = 0; m_sum = 0; m_ec = 0; m_idle = 0;
        end
      end else if (t_acc) begin
        m_idle = 0;
        t_w = {m_hi, in_data};
        if (m_n % 2 == 0) m_hi = in_data;
        else if (m_n == 1) m_addr = t_w;
        else if (m_n == 3) m_cnt = int'(t_w);
        else begin
          t_d = (m_n - 5) / 2;
          if (t_d < m_cnt) begin
            e_wen = 1; e_waddr = m_addr + 16'(t_d); e_wdata = t_w;
            m_sum = m_sum + t_w; m_ww = m_ww + 16'd1;
          end else if (t_w == m_sum) begin
            m_status = 1;
          end else begin
            m_status = 2; m_ec = 2'd1;
          end
        end
        m_n++;
      end else if (m_n > 0) begin
        m_idle++;
        if (m_idle == TO) begin m_status = 2; m_ec = 2'd2; end
      end
      m_rdy = (m_status == 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready", in_ready, m_rdy);
      chk("mem_w_en", mem_w_en, e_wen);
      chk("mem_w_addr", mem_w_addr, e_waddr);
      chk("mem_w_data", mem_w_data, e_wdata);
      chk("cpu_rst", cpu_rst, m_status != 1);
      chk("loaded", loaded, m_status == 1);
      chk("error", error, m_status == 2);
      chk("err_code", err_code, m_ec);
      chk("words_written", words_written, m_ww);
    end
  end

  logic [31:0] wlog[$];
  always @(negedge clk) if (rst && mem_w_en) wlog.push_back({mem_w_addr, mem_w_data});

  logic [7:0] fr[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit took;
    repeat (gap) begin in_valid = 0; @(posedge clk); #1; end
    in_valid = 1; in_data = b; took = 0;
    for (int k = 0; k < 8 && !took; k++) begin
      took = m_rdy;
      @(posedge clk); #1;
    end
    chk("byte_accepted", took, 1'b1);
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < fr.size(); i++)
      send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    in_valid = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1; @(posedge clk); #1; reload = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_mem_w_en"}, mem_w_en, 1'b0);
    chk({tag, "_mem_w_addr"}, mem_w_addr, 16'h0000);
    chk({tag, "_mem_w_data"}, mem_w_data, 16'h0000);
    chk({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    chk({tag, "_loaded"}, loaded, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_err_code"}, err_code, 2'd0);
    chk({tag, "_words_written"}, words_written, 16'd0);
  endtask

  task automatic chk_t1_writes(input string tag);
    chk({tag, "_nwrites"}, wlog.size(), 3);
    chk({tag, "_w0"}, wlog[0], 32'h3000_1234);
    chk({tag, "_w1"}, wlog[1], 32'h3001_ABCD);
    chk({tag, "_w2"}, wlog[2], 32'h3002_0001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk_reset_values("reset");
    #10 rst = 1;
    cycles(1);
    chk("ready_after_reset", in_ready, 1'b1);

    // 1: nominal three-word frame
    wlog.delete();
    fr = '{8'h30, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02};
    send_frame(0);
    cycles(2);
    chk_t1_writes("t1");
    chk("t1_loaded", loaded, 1'b1);
    chk("t1_cpu_rst", cpu_rst, 1'b0);
    chk("t1_ww", words_written, 16'd3);
    pulse_reload();

    // 2: bad checksum, reload, good resend
    fr[11] = 8'h03;
    send_frame(0);
    cycles(2);
    chk("t2_error", error, 1'b1);
    chk("t2_err_code", err_code, 2'd1);
    chk("t2_cpu_rst", cpu_rst, 1'b1);
    pulse_reload();
    chk("t2_reload_error", error, 1'b0);
    chk("t2_reload_ready", in_ready, 1'b1);
    fr[11] = 8'h02;
    send_frame(0);
    cycles(2);
    chk("t2_resend_loaded", loaded, 1'b1);
    pulse_reload();

    // 3: address wrap. A reload held during the first byte must be ignored.
    wlog.delete();
    fr = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h0B};
    reload = 1;
    send_byte(fr[0], 0);
    reload = 0;
    for (int i = 1; i < fr.size(); i++) send_byte(fr[i], 0);
    in_valid = 0;
    cycles(2);
    chk("t3_nwrites", wlog.size(), 2);
    chk("t3_w0", wlog[0], 32'hFFFF_0005);
    chk("t3_w1", wlog[1], 32'h0000_0006);
    chk("t3_loaded", loaded, 1'b1);
    pulse_reload();

    // 4: empty image
    wlog.delete();
    fr = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    cycles(2);
    chk("t4_nwrites", wlog.size(), 0);
    chk("t4_loaded", loaded, 1'b1);
    chk("t4_ww", words_written, 16'd0);
    pulse_reload();

    // 5: a 16-cycle stall times out; a 15-cycle stall is tolerated
    send_byte(8'h30, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    in_valid = 0;
    cycles(15);
    chk("t5_no_error_yet", error, 1'b0);
    cycles(1);
    chk("t5_error", error, 1'b1);
    chk("t5_err_code", err_code, 2'd2);
    pulse_reload();
    wlog.delete();
    fr = '{8'h30, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02};
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i], (i == 5) ? 15 : 0);
    in_valid = 0;
    cycles(2);
    chk_t1_writes("t5");
    chk("t5_loaded", loaded, 1'b1);
    pulse_reload();

    // 6: async reset just after a data high byte, then resend with random gaps
    for (int i = 0; i < 7; i++) send_byte(fr[i], 0);
    in_valid = 0;
    #2 rst = 0;
    #1 chk_reset_values("t6_async");
    #13 rst = 1;
    wlog.delete();
    send_frame(3);
    cycles(2);
    chk_t1_writes("t6");
    chk("t6_loaded", loaded, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
